// File: rtl/lsu_axi_master.sv
// Load/store unit bus master: turns one core load/store request into a single
// AXI-lite read or write, with byte-lane steering for stores and lane
// extraction plus sign/zero extension for loads. Misaligned requests are
// answered locally with an error and never reach the bus.
module lsu_axi_master #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // core request / response
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    output logic                  resp_valid,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  resp_err,
    // AXI-lite read channels
    output logic [ADDR_W-1:0]     araddr,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_W-1:0]     rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready,
    // AXI-lite write channels
    output logic [ADDR_W-1:0]     awaddr,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [DATA_W-1:0]     wdata,
    output logic [DATA_W/8-1:0]   wstrb,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready
);

    localparam int unsigned STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {
        StIdle,
        StRdAddr,
        StRdData,
        StWrReq,
        StWrResp,
        StResp
    } state_e;

    state_e      state_q;
    logic [1:0]  lane_q;
    logic [1:0]  size_q;
    logic        uns_q;

    logic [1:0]          req_lane;
    logic                req_misaligned;
    logic [DATA_W-1:0]   st_data;
    logic [STRB_W-1:0]   st_strb;
    logic [7:0]          rd_byte;
    logic [15:0]         rd_half;
    logic [DATA_W-1:0]   ld_data;

    assign req_lane = req_addr[1:0];

    // Handshake-side outputs are pure decodes of the state register.
    assign req_ready = (state_q == StIdle);
    assign rready    = (state_q == StRdData);
    assign bready    = (state_q == StWrResp);

    // Alignment check; the reserved size is always rejected.
    always_comb begin
        unique case (req_size)
            2'b00:   req_misaligned = 1'b0;
            2'b01:   req_misaligned = req_lane[0];
            2'b10:   req_misaligned = (req_lane != 2'b00);
            default: req_misaligned = 1'b1;
        endcase
    end

    // Steer store data and strobes onto the addressed byte lanes.
    always_comb begin
        st_data = req_wdata;
        st_strb = '1;
        unique case (req_size)
            2'b00: begin
                st_data = {{(DATA_W-8){1'b0}}, req_wdata[7:0]} << {req_lane, 3'b000};
                st_strb = STRB_W'(1) << req_lane;
            end
            2'b01: begin
                st_data = {{(DATA_W-16){1'b0}}, req_wdata[15:0]} << {req_lane, 3'b000};
                st_strb = STRB_W'(3) << req_lane;
            end
            default: ;
        endcase
    end

    // Pull the addressed lanes out of the returned word and extend them.
    always_comb begin
        rd_byte = 8'(rdata >> {lane_q, 3'b000});
        rd_half = 16'(rdata >> {lane_q, 3'b000});
        unique case (size_q)
            2'b00:   ld_data = {{(DATA_W-8){~uns_q & rd_byte[7]}}, rd_byte};
            2'b01:   ld_data = {{(DATA_W-16){~uns_q & rd_half[15]}}, rd_half};
            default: ld_data = rdata;
        endcase
    end

    // Transaction FSM with registered bus valids, addresses and response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            lane_q     <= 2'b00;
            size_q     <= 2'b00;
            uns_q      <= 1'b0;
            arvalid    <= 1'b0;
            awvalid    <= 1'b0;
            wvalid     <= 1'b0;
            araddr     <= '0;
            awaddr     <= '0;
            wdata      <= '0;
            wstrb      <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            resp_valid <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req_valid && req_ready) begin
                        lane_q <= req_lane;
                        size_q <= req_size;
                        uns_q  <= req_unsigned;
                        if (req_misaligned) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                            state_q    <= StResp;
                        end else if (req_we) begin
                            awaddr  <= req_addr;
                            wdata   <= st_data;
                            wstrb   <= st_strb;
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            state_q <= StWrReq;
                        end else begin
                            araddr  <= req_addr;
                            arvalid <= 1'b1;
                            state_q <= StRdAddr;
                        end
                    end
                end
                StRdAddr: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        state_q <= StRdData;
                    end
                end
                StRdData: begin
                    if (rvalid) begin
                        resp_valid <= 1'b1;
                        resp_err   <= (rresp != 2'b00);
                        resp_rdata <= (rresp != 2'b00) ? '0 : ld_data;
                        state_q    <= StResp;
                    end
                end
                StWrReq: begin
                    // A dropped valid doubles as the channel's done flag.
                    if (awvalid && awready) awvalid <= 1'b0;
                    if (wvalid && wready) wvalid <= 1'b0;
                    if ((!awvalid || awready) && (!wvalid || wready)) state_q <= StWrResp;
                end
                StWrResp: begin
                    if (bvalid) begin
                        resp_valid <= 1'b1;
                        resp_err   <= (bresp != 2'b00);
                        resp_rdata <= '0;
                        state_q    <= StResp;
                    end
                end
                StResp:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_axi_master.sv
// Directed bench for lsu_axi_master: the stimulus task plays the AXI-lite slave
// and pins literal results; a separate process checks every cycle against a
// spec-level reference model.
module tb_lsu_axi_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic        arvalid, arready, rvalid, rready, awvalid, awready;
    logic        wvalid, wready, bvalid, bready;
    logic [1:0]  rresp, bresp;
    logic [3:0]  wstrb;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } resp_t;
    resp_t exp_q[$];

    logic [31:0] cur_addr;
    logic        cur_mis;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wstrb;
    logic        ar_hold, aw_hold, w_hold;

    always #5 clk = ~clk;

    lsu_axi_master #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, wanted %h", name, act, exp);
        end
    endtask

    // ---------------- reference model (arithmetic on the access rules) -------------
    function automatic logic is_mis(input logic [31:0] a, input logic [1:0] sz);
        int off = int'(a % 4);
        if (sz == 2'd3) return 1'b1;
        if (sz == 2'd1) return (off % 2) != 0;
        if (sz == 2'd2) return off != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [31:0] a, input logic [1:0] sz,
                                            input logic [31:0] d);
        int off = int'(a % 4);
        if (sz == 2'd0) return (d % 256) * (32'd1 << (8 * off));
        if (sz == 2'd1) return (d % 65536) * (32'd1 << (8 * off));
        return d;
    endfunction

    function automatic logic [3:0] m_wstrb(input logic [31:0] a, input logic [1:0] sz);
        int off = int'(a % 4);
        if (sz == 2'd0) return 4'(1 << off);
        if (sz == 2'd1) return 4'(3 << off);
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_rdata(input logic [31:0] a, input logic [1:0] sz,
                                            input logic uns, input logic [31:0] d);
        int off = int'(a % 4);
        logic [31:0] v = d / (32'd1 << (8 * off));
        if (sz == 2'd0) begin
            v = v % 256;
            if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = v % 65536;
            if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
        end else begin
            v = d;
        end
        return v;
    endfunction

    // Remember whether each valid was pending (valid without ready) at the edge.
    always @(posedge clk) begin
        ar_hold <= arvalid && !arready;
        aw_hold <= awvalid && !awready;
        w_hold  <= wvalid && !wready;
    end

    // Per-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            if (resp_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected resp_valid", 32'd1, 32'd0);
                end else begin
                    resp_t e;
                    e = exp_q.pop_front();
                    check("model resp_rdata", resp_rdata, e.rdata);
                    check("model resp_err", 32'(resp_err), 32'(e.err));
                end
            end
            if (arvalid) check("model araddr", araddr, cur_addr);
            if (awvalid) check("model awaddr", awaddr, cur_addr);
            if (wvalid) begin
                check("model wdata", wdata, exp_wdata);
                check("model wstrb", 32'(wstrb), 32'(exp_wstrb));
            end
            if (ar_hold) check("arvalid held", 32'(arvalid), 32'd1);
            if (aw_hold) check("awvalid held", 32'(awvalid), 32'd1);
            if (w_hold) check("wvalid held", 32'(wvalid), 32'd1);
            if (cur_mis) check("no bus on misaligned", 32'({arvalid, awvalid, wvalid}), 32'd0);
        end
    end

    // Issue one request and act as the slave; wait_n stalls AR, R, AW and B.
    task automatic run_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                           input logic uns, input logic [31:0] wd, input logic [31:0] sd,
                           input logic [1:0] sresp, input int wait_n,
                           input logic [31:0] lit_rdata, input logic lit_err,
                           input logic [31:0] lit_wdata, input logic [3:0] lit_wstrb);
        int cyc = 0, done_cyc = 0, cnt = 0;
        int ar_n = 0, r_n = 0, aw_n = 0, w_n = 0, b_n = 0;
        bit aw_done = 0, done = 0, w_seen = 0;
        resp_t e;
        cur_addr  = addr;
        cur_mis   = is_mis(addr, size);
        exp_wdata = m_wdata(addr, size, wd);
        exp_wstrb = m_wstrb(addr, size);
        e.err     = cur_mis || (sresp != 2'b00);
        e.rdata   = (e.err || we) ? 32'd0 : m_rdata(addr, size, uns, sd);
        exp_q.push_back(e);
        @(negedge clk);
        check("req_ready before request", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
        req_unsigned = uns; req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
        while (!done && cyc < 100) begin
            if (resp_valid) begin
                check("resp_rdata literal", resp_rdata, lit_rdata);
                check("resp_err literal", 32'(resp_err), 32'(lit_err));
                done = 1; done_cyc = cyc;
            end
            if (wvalid && !w_seen) begin
                w_seen = 1;
                check("wdata literal", wdata, lit_wdata);
                check("wstrb literal", 32'(wstrb), 32'(lit_wstrb));
            end
            arready = 1'b0;
            if (arvalid) begin
                if (cnt >= wait_n) begin arready = 1'b1; ar_n++; cnt = 0; end else cnt++;
            end
            rvalid = 1'b0;
            if (rready) begin
                if (cnt >= wait_n) begin
                    rvalid = 1'b1; rdata = sd; rresp = sresp; r_n++; cnt = 0;
                end else cnt++;
            end
            // W only after AW has been accepted on an earlier edge.
            wready = 1'b0;
            if (wvalid && aw_done) begin wready = 1'b1; w_n++; end
            awready = 1'b0;
            if (awvalid) begin
                if (cnt >= wait_n) begin awready = 1'b1; aw_n++; aw_done = 1; cnt = 0; end
                else cnt++;
            end
            bvalid = 1'b0;
            if (bready) begin
                if (cnt >= wait_n) begin bvalid = 1'b1; bresp = sresp; b_n++; cnt = 0; end
                else cnt++;
            end
            @(negedge clk);
            cyc++;
        end
        if (!done) check("response timeout", 32'd0, 32'd1);
        check("resp_valid single cycle", 32'(resp_valid), 32'd0);
        check("req_ready after resp", 32'(req_ready), 32'd1);
        if (cur_mis) begin
            check("misaligned latency", 32'(done_cyc), 32'd0);
            check("misaligned bus beats", 32'(ar_n + aw_n + w_n), 32'd0);
        end else if (we) begin
            check("write beats ar/aw/w/b", {ar_n[7:0], aw_n[7:0], w_n[7:0], b_n[7:0]},
                  32'h0001_0101);
        end else begin
            check("read beats ar/r/aw/w", {ar_n[7:0], r_n[7:0], aw_n[7:0], w_n[7:0]},
                  32'h0101_0000);
            if (wait_n == 0) check("zero-wait load latency", 32'(done_cyc), 32'd2);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running, wanted done");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_size = 0; req_unsigned = 0;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        cur_addr = 0; cur_mis = 0; exp_wdata = 0; exp_wstrb = 0;
        #12;
        check("reset valids", 32'({arvalid, awvalid, wvalid, rready, bready, resp_valid, resp_err}),
              32'd0);
        check("reset req_ready", 32'(req_ready), 32'd1);
        check("reset addr/data", araddr | awaddr | wdata | resp_rdata | 32'(wstrb), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        //      we    addr           sz    uns   wdata          slave data     rsp  wt  rdata          err   wdata          strb
        run_req(1'b0, 32'h8000_0004, 2'd2, 1'b0, 32'h0,         32'hDEAD_BEEF, 2'd0, 3, 32'hDEAD_BEEF, 1'b0, 32'h0,         4'h0);
        run_req(1'b0, 32'h8000_0000, 2'd2, 1'b0, 32'h0,         32'h0102_0304, 2'd0, 0, 32'h0102_0304, 1'b0, 32'h0,         4'h0);
        run_req(1'b0, 32'h8000_0003, 2'd0, 1'b0, 32'h0,         32'h80FF_1234, 2'd0, 1, 32'hFFFF_FF80, 1'b0, 32'h0,         4'h0);
        run_req(1'b0, 32'h8000_0003, 2'd0, 1'b1, 32'h0,         32'h80FF_1234, 2'd0, 0, 32'h0000_0080, 1'b0, 32'h0,         4'h0);
        run_req(1'b0, 32'h8000_0001, 2'd0, 1'b0, 32'h0,         32'h80FF_1234, 2'd0, 0, 32'h0000_0012, 1'b0, 32'h0,         4'h0);
        run_req(1'b0, 32'h8000_0002, 2'd1, 1'b0, 32'h0,         32'h8001_1234, 2'd0, 0, 32'hFFFF_8001, 1'b0, 32'h0,         4'h0);
        run_req(1'b0, 32'h8000_0002, 2'd1, 1'b1, 32'h0,         32'h8001_1234, 2'd0, 2, 32'h0000_8001, 1'b0, 32'h0,         4'h0);
        run_req(1'b1, 32'h8000_0002, 2'd1, 1'b0, 32'h0000_ABCD, 32'h0,         2'd0, 2, 32'h0,         1'b0, 32'hABCD_0000, 4'hC);
        run_req(1'b1, 32'h8000_0001, 2'd0, 1'b0, 32'h0000_005A, 32'h0,         2'd0, 0, 32'h0,         1'b0, 32'h0000_5A00, 4'h2);
        run_req(1'b1, 32'h8000_0008, 2'd2, 1'b0, 32'hCAFE_F00D, 32'h0,         2'd0, 1, 32'h0,         1'b0, 32'hCAFE_F00D, 4'hF);
        run_req(1'b0, 32'h8000_0001, 2'd2, 1'b0, 32'h0,         32'h1111_1111, 2'd0, 0, 32'h0,         1'b1, 32'h0,         4'h0);
        run_req(1'b1, 32'h8000_0003, 2'd1, 1'b0, 32'h0000_1234, 32'h0,         2'd0, 0, 32'h0,         1'b1, 32'h0,         4'h0);
        run_req(1'b0, 32'h8000_0000, 2'd3, 1'b0, 32'h0,         32'h1111_1111, 2'd0, 0, 32'h0,         1'b1, 32'h0,         4'h0);
        run_req(1'b0, 32'h8000_000C, 2'd2, 1'b0, 32'h0,         32'hFFFF_FFFF, 2'd2, 1, 32'h0,         1'b1, 32'h0,         4'h0);
        run_req(1'b1, 32'h8000_000C, 2'd2, 1'b0, 32'h1234_5678, 32'h0,         2'd2, 0, 32'h0,         1'b1, 32'h1234_5678, 4'hF);

        // Reset while a store is stuck waiting for awready.
        cur_addr  = 32'h8000_0010; cur_mis = 1'b0;
        exp_wdata = 32'h1111_2222; exp_wstrb = 4'hF;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h8000_0010; req_size = 2'd2;
        req_wdata = 32'h1111_2222;
        @(negedge clk);
        req_valid = 1'b0; awready = 1'b0; wready = 1'b0;
        @(negedge clk);
        check("awvalid pending before reset", 32'(awvalid), 32'd1);
        #2 rst_n = 1'b0;
        arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
        #1;
        check("valids cleared by reset",
              32'({arvalid, awvalid, wvalid, rready, bready, resp_valid}), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("req_ready after reset", 32'(req_ready), 32'd1);
        run_req(1'b0, 32'h8000_0008, 2'd2, 1'b0, 32'h0, 32'h1234_5678, 2'd0, 1, 32'h1234_5678,
                1'b0, 32'h0, 4'h0);

        repeat (2) @(negedge clk);
        check("no responses left over", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lsu_axi_master.md
Name: lsu_axi_master

Overview:
- Load/store bus master placed between the core's memory stage and the data SRAM AXI-lite slave.
- Accepts one core load or store request at a time and converts it to a single AXI-lite read or write transaction.
- For stores: generates byte-lane write data and strobes.
- For loads: extracts the addressed lanes from the returned word and sign- or zero-extends them.
- Misaligned accesses are rejected locally with no bus traffic.

Parameters:
- ADDR_W, 32, address width of core request and AXI AR/AW channels.
- DATA_W, 32, data width; fixed 32 in this revision, WSTRB width = DATA_W/8.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  core request valid
- req_ready  out  1  high only in IDLE; request accepted when req_valid && req_ready
- req_we  in  1  1=store, 0=load
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data, value in low bits (byte/half/word)
- req_size  in  2  00=byte, 01=half, 10=word, 11=reserved (treated as misaligned)
- req_unsigned  in  1  load zero-extend (LBU/LHU) when 1
- resp_valid  out  1  one-cycle pulse on completion; core always accepts
- resp_rdata  out  DATA_W  extended load data; 0 for stores and errors
- resp_err  out  1  valid with resp_valid: misaligned, or non-OKAY rresp/bresp
- araddr  out  ADDR_W; arvalid out 1; arready in 1
- rdata in DATA_W; rresp in 2; rvalid in 1; rready out 1
- awaddr out ADDR_W; awvalid out 1; awready in 1
- wdata out DATA_W; wstrb out DATA_W/8; wvalid out 1; wready in 1
- bresp in 2; bvalid in 1; bready out 1

Behaviour:
- Reset (async, rst_n low):
  - State = IDLE; all valid/ready outputs 0 except req_ready = 1 once in IDLE.
  - araddr/awaddr/wdata/wstrb/resp_rdata = 0; resp_err = 0.
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP.
- IDLE, on request handshake:
  - Latch addr, size, unsigned, we. Compute lane = addr[1:0].
  - Misaligned (half with lane[0]=1, word with lane!=0, or size=11) → RESP with err=1, no AXI activity.
  - Aligned load → RD_ADDR; arvalid=1 registered, so it is visible the cycle after acceptance.
  - Aligned store → WR_REQ; awvalid=1 and wvalid=1 together.
  - Store lanes: wdata = req_wdata replicated/shifted to lane (byte: <<8*lane, half: <<8*lane, word: as-is). wstrb = 0001<<lane, 0011<<lane, or 1111.
- AXI addresses: araddr/awaddr carry the full byte address, unmodified.
- RD_ADDR:
  - Hold arvalid and araddr stable until arready.
  - On handshake, drop arvalid and go to RD_DATA (rready=1).
- RD_DATA:
  - On rvalid && rready, capture rdata and rresp; go to RESP.
  - Extraction: byte = rdata[8*lane+:8]; half = rdata[8*lane+:16]; word = rdata.
  - Sign-extend from bit 7/15 unless unsigned. err = (rresp != 00), and resp_rdata = 0 when err.
- WR_REQ:
  - AW and W are independent handshakes: track aw_done and w_done.
  - Each valid drops the cycle after its own handshake and is never reasserted.
  - The slave may raise wready only after AW is accepted, so wvalid is held indefinitely without depending on wready.
  - Both done → WR_RESP (bready=1). Same-cycle AW and W handshakes are legal.
- WR_RESP: on bvalid && bready → RESP, err = (bresp != 00).
- RESP: resp_valid=1 for exactly one cycle, then IDLE. req_ready returns the cycle after resp_valid.
- Latency: with a zero-wait slave, acceptance at cycle 0 → AR handshake cycle 1 → R handshake ≥ cycle 2 → resp_valid ≥ cycle 3.
- No AXI valid ever drops before its handshake. Valids are never asserted outside their own state.
- One outstanding transaction only. No timeout; a hung slave hangs the master.
- Reset mid-transaction: immediate return to IDLE with all valids low. The bench must reset the slave in the same cycle.

Test Plan:
- Aligned word load addr 0x8000_0004, slave returns 0xDEADBEEF after 3 wait cycles → one arvalid handshake with araddr=0x8000_0004; resp_valid pulse, resp_rdata=0xDEADBEEF, err=0.
- LB at 0x8000_0003, rdata=0x80FF_1234 → 0xFFFF_FF80; same access as LBU → 0x0000_0080.
- SH at 0x8000_0002, req_wdata=0x0000_ABCD, slave asserts wready only after AW → wdata=0xABCD_0000, wstrb=1100; wvalid held until wready; one B handshake, resp_err=0.
- LW at 0x8000_0001 and SH at 0x8000_0003 → no arvalid/awvalid ever; resp_valid 1 cycle after acceptance with resp_err=1, resp_rdata=0.
- Slave returns rresp=10 for a load and bresp=10 for a store → resp_err=1; load resp_rdata=0.
- rst_n low while in WR_REQ with awvalid high → same instant all valids 0; after release req_ready=1 and a new LW completes normally.
